// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, dcache op encoding and FSM state constants for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_e;

    localparam logic DC_OP_READ  = 1'b0;
    localparam logic DC_OP_WRITE = 1'b1;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;

    // dcache op: bit 2 selects write, bits 1:0 carry the access size unchanged
    function automatic logic [2:0] dc_op(input logic we, input logic [1:0] size);
        return {(we ? DC_OP_WRITE : DC_OP_READ), size};
    endfunction

    // low address bits that must be zero for a naturally aligned access of this size
    function automatic logic [1:0] size_mask(input logic [1:0] size);
        case (size_e'(size))
            SZ_B:    return 2'b00;
            SZ_H:    return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - execute-side request/response and dcache CPU-port signals of the load/store unit
interface lsu_if #(
    parameter int XLEN = 32,
    parameter int NREG = 5
) ();
    logic            i_stb;
    logic            i_we;
    logic [1:0]      i_size;
    logic            i_unsigned;
    logic [XLEN-1:0] i_addr;
    logic [XLEN-1:0] i_data;
    logic [NREG-1:0] i_rd;
    logic            o_busy;
    logic            o_valid;
    logic            o_err;
    logic [NREG-1:0] o_rd;
    logic [XLEN-1:0] o_data;
    logic            o_dc_stb;
    logic [2:0]      o_dc_op;
    logic [XLEN-1:0] o_dc_addr;
    logic [XLEN-1:0] o_dc_data;
    logic            i_dc_busy;
    logic            i_dc_valid;
    logic            i_dc_err;
    logic [XLEN-1:0] i_dc_data;

    modport slave (
        input  i_stb, i_we, i_size, i_unsigned, i_addr, i_data, i_rd,
        input  i_dc_busy, i_dc_valid, i_dc_err, i_dc_data,
        output o_busy, o_valid, o_err, o_rd, o_data,
        output o_dc_stb, o_dc_op, o_dc_addr, o_dc_data
    );

    modport master (
        output i_stb, i_we, i_size, i_unsigned, i_addr, i_data, i_rd,
        output i_dc_busy, i_dc_valid, i_dc_err, i_dc_data,
        input  o_busy, o_valid, o_err, o_rd, o_data,
        input  o_dc_stb, o_dc_op, o_dc_addr, o_dc_data
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store byte-lane replication (LOAD=0) or load extract/extend (LOAD=1)
module lsu_align
    import lsu_pkg::*;
#(
    parameter bit LOAD = 1'b0
) (
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  byte_off,
    input  logic [31:0] din,
    output logic [31:0] dout
);
    logic [31:0] shifted;
    logic [31:0] rep;
    logic [31:0] ext;

    // replicate the low bits across all lanes, or shift the addressed lanes down and extend
    always_comb begin
        shifted = din >> {byte_off, 3'b000};
        rep     = din;
        ext     = shifted;
        case (size_e'(size))
            SZ_B: begin
                rep = {4{din[7:0]}};
                ext = {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
            end
            SZ_H: begin
                rep = {2{din[15:0]}};
                ext = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
            end
            default: begin
                rep = din;
                ext = shifted;
            end
        endcase
        dout = LOAD ? ext : rep;
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - single-outstanding load/store unit in front of the dcache; LSU_MISALIGN_TRAP_EN traps misaligned accesses
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 5
) (
    input logic  i_clk,
    input logic  i_reset,
    lsu_if.slave bus
);
    state_t          state_q, state_d;
    logic            dc_stb_q, dc_stb_d;
    logic [2:0]      dc_op_q, dc_op_d;
    logic [XLEN-1:0] dc_addr_q, dc_addr_d;
    logic [XLEN-1:0] dc_data_q, dc_data_d;
    logic            unsigned_q, unsigned_d;
    logic [NREG-1:0] rd_q, rd_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [NREG-1:0] out_rd_q, out_rd_d;
    logic [XLEN-1:0] out_data_q, out_data_d;

    logic            req_illegal;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] store_rep;
    logic [XLEN-1:0] load_fmt;

    // legality check and the address actually sent to the dcache
    always_comb begin
        req_illegal = (bus.i_size == SZ_RSV);
        req_addr    = bus.i_addr;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((bus.i_addr[1:0] & size_mask(bus.i_size)) != 2'b00) begin
            req_illegal = 1'b1;
        end
`else
        req_addr = {bus.i_addr[XLEN-1:2], bus.i_addr[1:0] & ~size_mask(bus.i_size)};
`endif
    end

    lsu_align #(.LOAD(1'b0)) u_store_align (
        .size        (bus.i_size),
        .is_unsigned (1'b0),
        .byte_off    (2'b00),
        .din         (bus.i_data),
        .dout        (store_rep)
    );

    lsu_align #(.LOAD(1'b1)) u_load_align (
        .size        (dc_op_q[1:0]),
        .is_unsigned (unsigned_q),
        .byte_off    (dc_addr_q[1:0]),
        .din         (bus.i_dc_data),
        .dout        (load_fmt)
    );

    // request FSM: accept in IDLE, hold the dcache strobe until taken, then wait for completion
    always_comb begin
        state_d    = state_q;
        dc_stb_d   = dc_stb_q;
        dc_op_d    = dc_op_q;
        dc_addr_d  = dc_addr_q;
        dc_data_d  = dc_data_q;
        unsigned_d = unsigned_q;
        rd_d       = rd_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        out_rd_d   = out_rd_q;
        out_data_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_stb) begin
                    if (req_illegal) begin
                        err_d    = 1'b1;
                        out_rd_d = bus.i_rd;
                    end else begin
                        state_d    = ST_ISSUE;
                        dc_stb_d   = 1'b1;
                        dc_op_d    = dc_op(bus.i_we, bus.i_size);
                        dc_addr_d  = req_addr;
                        dc_data_d  = store_rep;
                        unsigned_d = bus.i_unsigned;
                        rd_d       = bus.i_rd;
                    end
                end
            end
            ST_ISSUE: begin
                if (!bus.i_dc_busy) begin
                    dc_stb_d = 1'b0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.i_dc_err) begin
                    err_d    = 1'b1;
                    out_rd_d = rd_q;
                    state_d  = ST_IDLE;
                end else if (bus.i_dc_valid) begin
                    valid_d    = 1'b1;
                    out_rd_d   = rd_q;
                    out_data_d = dc_op_q[2] ? '0 : load_fmt;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state and output registers; reset drops any request in flight
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            dc_stb_q   <= 1'b0;
            dc_op_q    <= '0;
            dc_addr_q  <= '0;
            dc_data_q  <= '0;
            unsigned_q <= 1'b0;
            rd_q       <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            out_rd_q   <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            dc_stb_q   <= dc_stb_d;
            dc_op_q    <= dc_op_d;
            dc_addr_q  <= dc_addr_d;
            dc_data_q  <= dc_data_d;
            unsigned_q <= unsigned_d;
            rd_q       <= rd_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            out_rd_q   <= out_rd_d;
            out_data_q <= out_data_d;
        end
    end

    assign bus.o_busy    = (state_q != ST_IDLE);
    assign bus.o_valid   = valid_q;
    assign bus.o_err     = err_q;
    assign bus.o_rd      = out_rd_q;
    assign bus.o_data    = out_data_q;
    assign bus.o_dc_stb  = dc_stb_q;
    assign bus.o_dc_op   = dc_op_q;
    assign bus.o_dc_addr = dc_addr_q;
    assign bus.o_dc_data = dc_data_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - scoreboard bench for lsu with a dcache model and a byte-level memory reference
module tb_lsu;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_if bus ();
    lsu dut (.i_clk(clk), .i_reset(rst), .bus(bus));

    typedef struct {
        logic        err;
        logic [4:0]  rd;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  op;
        logic [31:0] data;
        int          busy;
        int          delay;
        logic        err;
    } dc_t;

    resp_t       expq[$];
    dc_t         dcq[$];
    logic [7:0]  rmem[1024];
    logic [31:0] cmem[256];
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] w);
        cmem[a[9:2]] = w;
        for (int i = 0; i < 4; i++) rmem[(a & 32'h3FC) + i] = w[8*i +: 8];
    endtask

    function automatic logic [31:0] rep_ref(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        int n;
        n = 1 << size;
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    // memory-level model: bytes are read/written at the effective address, then extended
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                         input int busy, input int delay, input logic derr, input logic track);
        int guard;
        int n;
        logic illegal;
        logic [31:0] eff;
        logic [31:0] v;
        resp_t r;
        dc_t e;
        guard = 0;
        while (bus.o_busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (bus.o_busy) chk("issue_timeout", 32'(bus.o_busy), 32'd0);
        n = 1 << size;
        illegal = (size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        if (!illegal && (addr % n) != 0) illegal = 1'b1;
        eff = addr;
`else
        eff = illegal ? addr : addr - (addr % n);
`endif
        r.rd = rd;
        r.data = '0;
        r.err = 1'b1;
        if (!illegal) begin
            e.addr = eff; e.op = {we, size}; e.data = rep_ref(size, data);
            e.busy = busy; e.delay = delay; e.err = derr;
            dcq.push_back(e);
            if (!derr) begin
                r.err = 1'b0;
                if (we) begin
                    for (int i = 0; i < n; i++) rmem[eff + i] = data[8*i +: 8];
                end else begin
                    v = '0;
                    for (int i = 0; i < n; i++) v[8*i +: 8] = rmem[eff + i];
                    if (!uns && n < 4 && v[8*n-1])
                        for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
                    r.data = v;
                end
            end
        end
        if (track) expq.push_back(r);
        bus.i_stb = 1'b1; bus.i_we = we; bus.i_size = size; bus.i_unsigned = uns;
        bus.i_addr = addr; bus.i_data = data; bus.i_rd = rd;
        @(negedge clk);
        bus.i_stb = 1'b0; bus.i_we = 1'($urandom); bus.i_size = 2'($urandom);
        bus.i_addr = $urandom; bus.i_data = $urandom; bus.i_rd = 5'($urandom);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((expq.size() != 0 || bus.o_busy) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_pending", 32'(expq.size()), 32'd0);
    endtask

    // dcache model: checks issued fields, stalls, then completes from its own word memory
    initial begin
        dc_t e;
        logic [31:0] a0;
        int lane;
        bus.i_dc_busy = 1'b0; bus.i_dc_valid = 1'b0; bus.i_dc_err = 1'b0; bus.i_dc_data = '0;
        forever begin
            @(negedge clk);
            if (bus.o_dc_stb && !rst) begin
                if (dcq.size() == 0) begin
                    chk("dc_unexpected_stb", 32'd1, 32'd0);
                end else begin
                    e = dcq.pop_front();
                    chk("dc_addr", bus.o_dc_addr, e.addr);
                    chk("dc_op", 32'(bus.o_dc_op), 32'(e.op));
                    if (e.op[2]) chk("dc_data", bus.o_dc_data, e.data);
                    a0 = bus.o_dc_addr;
                    for (int k = 0; k < e.busy; k++) begin
                        bus.i_dc_busy = 1'b1;
                        bus.i_dc_valid = 1'($urandom);
                        @(negedge clk);
                        chk("dc_hold_stb", 32'(bus.o_dc_stb), 32'd1);
                        chk("dc_hold_addr", bus.o_dc_addr, a0);
                    end
                    bus.i_dc_busy = 1'b0;
                    bus.i_dc_valid = 1'b0;
                    @(negedge clk);
                    chk("dc_stb_drop", 32'(bus.o_dc_stb), 32'd0);
                    repeat (e.delay) @(negedge clk);
                    if (e.op[2] && !e.err) begin
                        for (int i = 0; i < (1 << e.op[1:0]); i++) begin
                            lane = int'(e.addr[1:0]) + i;
                            cmem[e.addr[9:2]][8*lane +: 8] = bus.o_dc_data[8*lane +: 8];
                        end
                    end
                    bus.i_dc_data = cmem[e.addr[9:2]];
                    bus.i_dc_err = e.err;
                    bus.i_dc_valid = e.err ? 1'($urandom) : 1'b1;
                    @(negedge clk);
                    bus.i_dc_valid = 1'b0;
                    bus.i_dc_err = 1'b0;
                    bus.i_dc_data = $urandom;
                end
            end
        end
    end

    // response monitor: every completion pulse is matched against the oldest expectation
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (bus.o_valid || bus.o_err) begin
                pulses++;
                if (bus.o_valid && bus.o_err) chk("valid_err_exclusive", 32'd1, 32'd0);
                if (expq.size() == 0) begin
                    chk("unexpected_resp", {30'd0, bus.o_valid, bus.o_err}, 32'd0);
                end else begin
                    r = expq.pop_front();
                    chk("resp_err", 32'(bus.o_err), 32'(r.err));
                    chk("resp_valid", 32'(bus.o_valid), 32'(!r.err));
                    chk("resp_rd", 32'(bus.o_rd), 32'(r.rd));
                    chk("resp_data", bus.o_data, r.data);
                end
            end
        end
    end

    initial begin
        int p0;
        int sel;
        logic [1:0] sz;
        rst = 1'b1;
        bus.i_stb = 1'b0; bus.i_we = 1'b0; bus.i_size = '0; bus.i_unsigned = 1'b0;
        bus.i_addr = '0; bus.i_data = '0; bus.i_rd = '0;
        for (int w = 0; w < 256; w++) poke(32'(w * 4), $urandom);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_err", 32'(bus.o_err), 32'd0);
        chk("rst_rd", 32'(bus.o_rd), 32'd0);
        chk("rst_data", bus.o_data, 32'd0);
        chk("rst_dc_stb", 32'(bus.o_dc_stb), 32'd0);
        chk("rst_dc_op", 32'(bus.o_dc_op), 32'd0);
        chk("rst_dc_addr", bus.o_dc_addr, 32'd0);
        chk("rst_dc_data", bus.o_dc_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        poke(32'h100, 32'hDEADBEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd7, 0, 2, 1'b0, 1'b1);
        drain();

        poke(32'h100, 32'h80123456);
        issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd3, 0, 0, 1'b0, 1'b1);
        issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd4, 1, 1, 1'b0, 1'b1);
        drain();

        issue(1'b1, 2'b01, 1'b0, 32'h202, 32'h5555ABCD, 5'd9, 3, 1, 1'b0, 1'b1);
        chk("hstore_op", 32'(bus.o_dc_op), 32'h5);
        chk("hstore_data", bus.o_dc_data, 32'hABCDABCD);
        drain();

        issue(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd11, 0, 0, 1'b0, 1'b1);
`ifdef LSU_MISALIGN_TRAP_EN
        for (int k = 0; k < 4; k++) begin
            chk("trap_no_dc_stb", 32'(bus.o_dc_stb), 32'd0);
            @(negedge clk);
        end
`else
        chk("align_dc_addr", bus.o_dc_addr, 32'h100);
`endif
        drain();

        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 5'd12, 0, 1, 1'b1, 1'b1);
        for (int k = 0; k < 20 && !bus.o_err; k++) @(negedge clk);
        chk("dc_err_pulse", 32'(bus.o_err), 32'd1);
        chk("dc_err_not_busy", 32'(bus.o_busy), 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 5'd13, 0, 0, 1'b0, 1'b1);
        chk("b2b_accept", 32'(bus.o_dc_stb), 32'd1);
        drain();

        issue(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 5'd14, 0, 3, 1'b0, 1'b0);
        @(negedge clk);
        p0 = pulses;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("reset_drop_busy", 32'(bus.o_busy), 32'd0);
        repeat (6) @(negedge clk);
        chk("reset_no_pulse", 32'(pulses - p0), 32'd0);

        for (int t = 0; t < 150; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            sel = $urandom_range(0, 9);
            sz = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            issue(1'($urandom), sz, 1'($urandom), 32'($urandom_range(0, 1023)), $urandom,
                  5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 7) == 0), 1'b1);
        end
        drain();
        repeat (4) @(negedge clk);
        chk("dcq_empty", 32'(dcq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

- Load/store unit sitting directly upstream of the data cache.
- Accepts one memory request at a time from the execute stage and issues it to the dcache CPU port.
- Waits for completion, then returns aligned, size-masked, sign/zero-extended load data (or a store acknowledge) to writeback.
- Handles byte-lane replication for stores, alignment checking and error reporting, and stalls the pipeline while a request is outstanding.

## Interface
Parameters:
- XLEN, 32, data/address width; must be 32.
- NREG, 5, width of destination register tag.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_stb  in  1  execute stage presents a request; sampled only when o_busy=0.
- i_we  in  1  1=store, 0=load.
- i_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- i_unsigned  in  1  loads: zero-extend instead of sign-extend.
- i_addr  in  XLEN  byte address.
- i_data  in  XLEN  store data; value sits in the low bits.
- i_rd  in  NREG  destination register tag, echoed on completion.
- o_busy  out  1  request in flight; execute must hold.
- o_valid  out  1  one-cycle completion pulse.
- o_err  out  1  one-cycle error pulse; mutually exclusive with o_valid.
- o_rd  out  NREG  tag of completed request.
- o_data  out  XLEN  formatted load data; 0 for stores and errors.
- o_dc_stb  out  1  request to dcache.
- o_dc_op  out  3  [2]=write, [1:0]=size (same encoding as i_size).
- o_dc_addr  out  XLEN  full byte address.
- o_dc_data  out  XLEN  lane-replicated store data.
- i_dc_busy  in  1  dcache cannot accept this cycle.
- i_dc_valid  in  1  dcache completion.
- i_dc_err  in  1  dcache bus error.
- i_dc_data  in  XLEN  raw aligned word from dcache.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - i_stb=1 with legal size/alignment: latch request, go to ISSUE.
  - i_stb=1 with illegal request: pulse o_err next cycle, stay IDLE.
- ISSUE:
  - o_dc_stb=1, request fields held stable.
  - Handshake completes on a cycle with o_dc_stb && !i_dc_busy; next state WAIT.
  - i_dc_valid/i_dc_err in ISSUE are ignored.
- WAIT:
  - On i_dc_valid: register formatted result, pulse o_valid, go to IDLE.
  - On i_dc_err: o_err pulse, o_data=0, go to IDLE. i_dc_err wins over i_dc_valid if both are asserted.
- Store replication:
  - byte: {4{d[7:0]}}.
  - half: {2{d[15:0]}}.
  - word: d.
- Load extract:
  - w = i_dc_data >> (8*addr[1:0]).
  - Mask to size, then sign-extend from bit 7/15 unless i_unsigned.
  - Word loads ignore i_unsigned.
- Illegal requests: size=11 always; misalignment per Configuration.
- o_busy = (state != IDLE).
- i_stb while busy is ignored.
- Reset in any state: go to IDLE and drop the request; no o_valid/o_err pulse for it.
- Reset values: all outputs 0.

## Timing
- Accept at edge N; o_dc_stb high during cycle N+1.
- Dcache completion in cycle M produces o_valid/o_err in cycle M+1.
- FSM is IDLE in cycle M+1, so a new i_stb can be accepted that same cycle (back-to-back throughput).
- Minimum latency with zero-wait cache (accept N+1, valid N+2): o_valid in N+3.
- o_dc_stb, o_dc_op, o_dc_addr and o_dc_data are registered and change only on accept.

## Configuration
- LSU_MISALIGN_TRAP_EN:
  - Defined: half with addr[0]=1, or word with addr[1:0]!=0, is illegal. o_err pulses one cycle after the request; no dcache access is issued.
  - Undefined: the low address bits are cleared to natural alignment, and the access is issued and completes normally.

## Structure
- Package lsu_pkg holds:
  - size enum (SZ_B, SZ_H, SZ_W);
  - dcache op encoding constants;
  - FSM state enum.
- Sub-module lsu_align: combinational store-lane replication and load extract/extend; instantiated once for each direction's function.

## Test plan
- Word load 0x100, cache returns 0xDEADBEEF after 2 cycles -> o_valid, o_data=0xDEADBEEF, o_rd echoed.
- Byte load addr 0x103, i_dc_data=0x80123456:
  - signed -> 0xFFFFFF80;
  - i_unsigned -> 0x00000080.
- Half store 0xABCD at 0x202 -> o_dc_op=3'b101, o_dc_data=0xABCDABCD; i_dc_busy high 3 cycles keeps o_dc_stb and fields stable.
- Word load at 0x101:
  - macro defined -> o_err, o_dc_stb never rises;
  - undefined -> o_dc_addr=0x100.
- i_dc_err in WAIT -> o_err one cycle, o_data=0, next i_stb accepted in that cycle.
- i_reset in WAIT, then late i_dc_valid -> no o_valid, o_busy=0.
